ansi_localparam_gather: RTL and testbench
=========================================

// Module: ansi_localparam_gather
// PURPOSE
//   Width-gathering receiver: accepts a stream of WIDTH-bit beats (valid/ready) and packs
//   DEPTH beats into one WIDTH*DEPTH-bit word (valid/ready). Early packing on in_last.
//   Receive-side partner of the narrow-bus passthrough blocks.
//   Derived widths are ANSI-header localparams so the port list uses them directly.
// PARAMETERS
//   WIDTH  2                  beat width in bits, >=1
//   DEPTH  4                  beats per packed word, >=2
//   OUT_W  WIDTH*DEPTH        localparam in #( ) header; packed word width
//   CNT_W  $clog2(DEPTH+1)    localparam in #( ) header; beat-count width
// PORTS
//   CLK        in   1      clock, all state on rising edge
//   RST        in   1      synchronous, active-high reset
//   in_valid   in   1      input beat present
//   in_ready   out  1      input beat accepted when in_valid&&in_ready
//   in_data    in   WIDTH  input beat
//   in_last    in   1      final beat of frame; forces early word emission
//   out_valid  out  1      packed word present
//   out_ready  in   1      downstream accepts when out_valid&&out_ready
//   out_data   out  OUT_W  packed word, beat 0 in bits [WIDTH-1:0]
//   out_count  out  CNT_W  number of valid beats in out_data (1..DEPTH)
// BEHAVIOUR
//   - Reset (RST=1 at edge): out_valid=0, out_data=0, out_count=0, beat counter=0,
//     assembly reg=0. in_ready is 0 while RST=1. Reset mid-word discards the partial word.
//   - Two registers: assembly reg (asm, cnt) and output slot (out_data/out_count/out_valid).
//   - Beat k of a word (k=cnt) is written to asm[k*WIDTH +: WIDTH]; unwritten bits stay 0.
//   - A beat is "closing" when cnt==DEPTH-1 or in_last=1.
//   - in_ready = !RST && (!closing_candidate || !out_valid || out_ready), where
//     closing_candidate = (cnt==DEPTH-1) || in_last. Non-closing beats are always accepted.
//   - On accepted non-closing beat: cnt <= cnt+1.
//   - On accepted closing beat: out_data <= asm with the beat merged, out_count <= cnt+1,
//     out_valid <= 1, asm <= 0, cnt <= 0. Latency: the word is visible one cycle after the
//     closing beat's handshake.
//   - Output handshake with no new closing beat: out_valid <= 0. The out_data and
//     out_count registers hold their previous values.
//   - Simultaneous out handshake and closing beat accept: the new word loads and
//     out_valid stays 1. Back-to-back words then run at full rate with no bubble.
//   - out_valid && !out_ready: out_data/out_count stable. A closing beat stalls
//     (in_ready=0). Non-closing beats of the next word continue to fill asm.
//   - in_last on beat 0 gives out_count=1 and bits [OUT_W-1:WIDTH]=0.
//   - in_valid=0 has no effect on state. in_data/in_last are ignored unless the beat is accepted.
//   - Counter never exceeds DEPTH-1. No overflow/underflow conditions exist.
// TESTING
//   T1 WIDTH=2,DEPTH=4; beats 1,2,3,0 continuous, out_ready=1 -> next cycle out_valid=1,
//      out_data=8'h39, out_count=4; out_valid drops the cycle after.
//   T2 beats 3,1 with in_last on 2nd -> out_data=8'h07, out_count=2.
//   T3 out_ready=0 holding word A; send 3 beats of word B then 4th -> first 3 accepted,
//      in_ready=0 on 4th; raise out_ready -> A taken, B loads same cycle, out_valid stays 1.
//   T4 continuous stream of 3 words with out_ready=1 -> exactly one word per 4 accepted
//      beats, in_ready never drops, out_valid high every 4th cycle.
//   T5 RST=1 after 2 beats of a word, then beats 1,1,1,1 -> out_data=8'h55, count=4
//      (no stale bits); in_ready=0 and out_valid=0 during reset.
//   T6 in_last on beat 0, data=2 -> out_data=8'h02, out_count=1; random-stall soak
//      vs reference packer model shows no lost or duplicated beats.

Source files
------------

// File: rtl/ansi_localparam_gather.sv
`default_nettype none
// ============================================================================
// Module      : ansi_localparam_gather
// Description : Width-gathering receiver. Packs DEPTH WIDTH-bit beats into one
//               WIDTH*DEPTH-bit word, emitting early when in_last is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module ansi_localparam_gather #(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 4,
    localparam int OUT_W = WIDTH * DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(DEPTH - 1);

    logic [OUT_W-1:0] r_asm;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_valid;

    logic             w_closing;
    logic             w_accept;
    logic [OUT_W-1:0] w_beat_shifted;
    logic [OUT_W-1:0] w_merged;

    // A closing beat needs the output slot free (or freeing this cycle);
    // all other beats only touch the assembly register and never stall.
    assign w_closing      = (r_cnt == c_last_idx) || in_last;
    assign in_ready       = !RST && (!w_closing || !r_out_valid || out_ready);
    assign w_accept       = in_valid && in_ready;
    assign w_beat_shifted = OUT_W'(in_data) << (int'(r_cnt) * WIDTH);
    assign w_merged       = r_asm | w_beat_shifted;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_asm       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            // A closing accept overrides the drop above so words flow back-to-back.
            if (w_accept) begin
                if (w_closing) begin
                    r_out_data  <= w_merged;
                    r_out_count <= r_cnt + CNT_W'(1);
                    r_out_valid <= 1'b1;
                    r_asm       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_asm <= w_merged;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_ansi_localparam_gather.sv
`default_nettype none
// ============================================================================
// Module      : tb_ansi_localparam_gather
// Description : Scoreboard bench for ansi_localparam_gather (WIDTH=2, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ansi_localparam_gather;

    localparam int W  = 2;
    localparam int D  = 4;
    localparam int OW = W * D;
    localparam int CW = $clog2(D + 1);

    typedef struct {
        logic [OW-1:0] data;
        int            count;
    } word_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [CW-1:0] out_count;

    int         checks = 0;
    int         errors = 0;
    bit         rand_en = 1'b0;
    word_t      exp_q[$];
    logic [W-1:0] frame[$];

    ansi_localparam_gather #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK      (clk),
        .RST      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor / reference model: a frame is a list of beats; it becomes a word
    // once it holds DEPTH beats or a beat arrives flagged last.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("ready_in_reset", {31'b0, in_ready}, 32'd0);
                exp_q.delete();
                frame.delete();
            end else begin
                logic exp_ready;
                chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
                if (out_valid && exp_q.size() != 0) begin
                    chk("out_data", {24'b0, out_data}, {24'b0, exp_q[0].data});
                    chk("out_count", {29'b0, out_count}, exp_q[0].count);
                end
                exp_ready = !(((frame.size() == D - 1) || in_last) &&
                              (exp_q.size() != 0) && !out_ready);
                chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                end
                if (in_valid && in_ready) begin
                    frame.push_back(in_data);
                    if (frame.size() == D || in_last) begin
                        word_t w;
                        w.data  = '0;
                        w.count = frame.size();
                        for (int k = 0; k < frame.size(); k++) begin
                            w.data = w.data + OW'(frame[k]) * OW'(1 << (W * k));
                        end
                        exp_q.push_back(w);
                        frame.delete();
                    end
                end
            end
        end
    end

    task automatic step_edge();
        @(posedge clk);
        #1;
        if (rand_en) out_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic send(input logic [W-1:0] d, input logic l, output int waited);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
            step_edge();
        end
        step_edge();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = W'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wt;
        int total;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) step_edge();
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {24'b0, out_data}, 32'd0);
        chk("rst_out_count", {29'b0, out_count}, 32'd0);
        step_edge();
        rst = 1'b0;
        step_edge();

        // T1: full word 1,2,3,0
        send(2'd1, 1'b0, wt); send(2'd2, 1'b0, wt); send(2'd3, 1'b0, wt); send(2'd0, 1'b0, wt);
        @(negedge clk);
        chk("t1_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_data", {24'b0, out_data}, 32'h39);
        chk("t1_count", {29'b0, out_count}, 32'd4);
        @(negedge clk);
        chk("t1_valid_drop", {31'b0, out_valid}, 32'd0);
        step_edge();

        // T2: early word via in_last
        send(2'd3, 1'b0, wt); send(2'd1, 1'b1, wt);
        @(negedge clk);
        chk("t2_data", {24'b0, out_data}, 32'h07);
        chk("t2_count", {29'b0, out_count}, 32'd2);
        step_edge();

        // T3: word A held, B fills behind it, closing beat stalls
        out_ready = 1'b0;
        send(2'd0, 1'b0, wt); send(2'd1, 1'b0, wt); send(2'd2, 1'b0, wt); send(2'd3, 1'b0, wt);
        total = 0;
        send(2'd3, 1'b0, wt); total += wt;
        send(2'd3, 1'b0, wt); total += wt;
        send(2'd2, 1'b0, wt); total += wt;
        chk("t3_fill_no_stall", total, 32'd0);
        in_valid = 1'b1; in_data = 2'd1; in_last = 1'b0;
        @(negedge clk);
        chk("t3_stall", {31'b0, in_ready}, 32'd0);
        chk("t3_hold_a", {24'b0, out_data}, 32'hE4);
        step_edge();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_release", {31'b0, in_ready}, 32'd1);
        step_edge();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_b_valid", {31'b0, out_valid}, 32'd1);
        chk("t3_b_data", {24'b0, out_data}, 32'h6F);
        step_edge();

        // T4: three back-to-back words, no stall expected
        total = 0;
        for (int i = 0; i < 3 * D; i++) begin
            send(W'($urandom), 1'b0, wt);
            total += wt;
        end
        chk("t4_no_stall", total, 32'd0);

        // T5: reset mid-word discards partial beats
        send(2'd2, 1'b0, wt); send(2'd3, 1'b0, wt);
        rst = 1'b1;
        @(negedge clk);
        step_edge();
        @(negedge clk);
        chk("t5_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("t5_rst_data", {24'b0, out_data}, 32'd0);
        step_edge();
        rst = 1'b0;
        for (int i = 0; i < D; i++) send(2'd1, 1'b0, wt);
        @(negedge clk);
        chk("t5_data", {24'b0, out_data}, 32'h55);
        chk("t5_count", {29'b0, out_count}, 32'd4);
        step_edge();

        // T6: last on beat 0, then random-stall soak
        send(2'd2, 1'b1, wt);
        @(negedge clk);
        chk("t6_data", {24'b0, out_data}, 32'h02);
        chk("t6_count", {29'b0, out_count}, 32'd1);
        step_edge();
        rand_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) step_edge();
            send(W'($urandom), ($urandom_range(0, 5) == 0), wt);
        end
        send(W'($urandom), 1'b1, wt);
        rand_en   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            step_edge();
        end
        repeat (2) step_edge();
        chk("drain_empty", exp_q.size(), 32'd0);
        chk("frame_empty", frame.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
